// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: pipelined Wishbone fetch into a DEPTH-entry {PC, IR} FIFO.
// Optional bus-error reporting is enabled with `define FETCH_ERR_EN (adds wb_err_i / ins_fault).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
`ifdef FETCH_ERR_EN
  input  logic        wb_err_i,
  output logic        ins_fault,
`endif
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  input  logic        jump,
  input  logic [31:0] jump_target
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CW-1:0] count, pend, drop;
  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   tag_mem [DEPTH];
  logic [SW-1:0] used;
  logic          halted, bus_done, bus_err;
  logic          accept, live_ack, drop_ack, any_ack, pop;

`ifdef FETCH_ERR_EN
  logic fault_mem [DEPTH];
  assign bus_done = wb_ack_i | wb_err_i;
  assign bus_err  = wb_err_i;
`else
  assign bus_done = wb_ack_i;
  assign bus_err  = 1'b0;
  assign halted   = 1'b0;
`endif

  // Stale (dropped) requests still hold credits until their acks drain.
  assign used     = SW'(count) + SW'(pend) + SW'(drop);
  assign wb_stb_o = rst && !jump && !halted && (used < SW'(DEPTH));
  assign wb_cyc_o = wb_stb_o || (pend != '0) || (drop != '0);
  assign wb_adr_o = fetch_pc;

  assign accept   = wb_stb_o && !wb_stall_i;
  assign any_ack  = bus_done && ((drop != '0) || (pend != '0));
  assign drop_ack = bus_done && (drop != '0);
  assign live_ack = bus_done && (drop == '0) && (pend != '0) && !jump;
  assign pop      = ins_valid && ins_ready;
  // Oldest pending tag sits pend slots behind the write pointer.
  assign tag_rd   = tag_wr - AW'(pend);

  assign ins_valid = (count != '0);
  assign pc_o      = pc_mem[rd_ptr];
  assign ir_o      = ir_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      pend     <= '0;
      drop     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ir_mem[i]  <= '0;
        tag_mem[i] <= '0;
      end
    end else if (jump) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend     <= '0;
      drop     <= drop + pend + CW'(accept) - CW'(any_ack);
      fetch_pc <= {jump_target[31:2], 2'b00};
    end else begin
      if (accept) begin
        fetch_pc        <= fetch_pc + 32'd4;
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_wr + 1'b1;
      end
      pend <= pend + CW'(accept) - CW'(live_ack);
      drop <= drop - CW'(drop_ack);
      if (live_ack) begin
        pc_mem[wr_ptr] <= tag_mem[tag_rd];
        ir_mem[wr_ptr] <= bus_err ? NOP : wb_dat_i;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(live_ack) - CW'(pop);
    end
  end

`ifdef FETCH_ERR_EN
  assign ins_fault = fault_mem[rd_ptr];

  // A faulted fetch stops prefetching until software redirects with a jump.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fault_mem[i] <= 1'b0;
    end else begin
      if (jump) halted <= 1'b0;
      else if (live_ack && wb_err_i) halted <= 1'b1;
      if (live_ack) fault_mem[wr_ptr] <= wb_err_i;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model plus a latency-configurable Wishbone slave.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk, rst;
  logic        wb_cyc_o, wb_stb_o, wb_stall_i, wb_ack_i;
  logic [31:0] wb_adr_o, wb_dat_i;
  logic        ins_valid, ins_ready, jump;
  logic [31:0] pc_o, ir_o, jump_target;
`ifdef FETCH_ERR_EN
  logic        ins_fault;
`endif

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
`ifdef FETCH_ERR_EN
    .wb_err_i(1'b0), .ins_fault(ins_fault),
`endif
    .ins_valid(ins_valid), .ins_ready(ins_ready), .pc_o(pc_o), .ir_o(ir_o),
    .jump(jump), .jump_target(jump_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit stale; } ifl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
  typedef struct { logic [31:0] adr; int due; } sreq_t;

  ifl_t        ifl[$];
  ent_t        fq[$];
  sreq_t       sq[$];
  logic [31:0] m_pc;
  int          total, bad, cyc_no, lat, vcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit j, input logic [31:0] jt, input bit rdy, input bit stl);
    bit          exp_stb, ack, acc;
    logic [31:0] dat;
    ifl_t        f;
    ent_t        e;
    jump        = j;
    jump_target = jt;
    ins_ready   = rdy;
    wb_stall_i  = stl;
    ack         = (sq.size() != 0) && (sq[0].due <= cyc_no);
    dat         = ack ? (sq[0].adr ^ 32'hA5A5_0000) : $urandom;
    wb_ack_i    = ack;
    wb_dat_i    = dat;
    @(negedge clk);
    exp_stb = !j && ((fq.size() + ifl.size()) < DEPTH);
    chk("stb", 32'(wb_stb_o), 32'(exp_stb));
    chk("adr", wb_adr_o, m_pc);
    chk("cyc", 32'(wb_cyc_o), 32'(exp_stb || (ifl.size() != 0)));
    chk("valid", 32'(ins_valid), 32'(fq.size() != 0));
    if (fq.size() != 0) begin
      chk("pc", pc_o, fq[0].pc);
      chk("ir", ir_o, fq[0].ir);
      if (rdy) vcnt++;
    end
    if (wb_stb_o && !stl) sq.push_back('{wb_adr_o, cyc_no + 1 + lat});
    if (ack) void'(sq.pop_front());
    acc = exp_stb && !stl;
    if (rdy && fq.size() != 0) void'(fq.pop_front());
    if (ack && ifl.size() != 0) begin
      f = ifl.pop_front();
      if (!f.stale && !j) begin
        e.pc = f.pc;
        e.ir = dat;
        fq.push_back(e);
      end
    end
    if (j) begin
      fq.delete();
      foreach (ifl[i]) ifl[i].stale = 1'b1;
      m_pc = {jt[31:2], 2'b00};
    end else if (acc) begin
      ifl.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1'b0; jump = 1'b0; jump_target = '0; ins_ready = 1'b0;
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = '0;
    ifl.delete(); fq.delete(); sq.delete();
    m_pc = RPC;
    @(negedge clk);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_adr", wb_adr_o, RPC);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_ir", ir_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc_no = 0;
  endtask

  initial begin
    total = 0; bad = 0; lat = 0; vcnt = 0;
    do_reset();

    // Zero-wait slave, always-ready consumer: valid from cycle 2, one per cycle.
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("throughput", 32'(vcnt), 32'd18);

    // Consumer stalls: fetch stops once DEPTH credits are used.
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Slave stall for 3 cycles.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Three requests in flight on a slow slave, then redirect to 0x100.
    cycle(1'b1, 32'h0000_0040, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    lat = 3;
    cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0);
    chk("jmp_adr", wb_adr_o, 32'h0000_0100);
    for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Misaligned target.
    lat = 0;
    cycle(1'b1, 32'h0000_0203, 1'b1, 1'b0);
    chk("align_adr", wb_adr_o, 32'h0000_0200);
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) lat = $urandom_range(0, 3);
      cycle($urandom_range(0, 30) == 0, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    end

    // Reset in the middle of traffic.
    lat = 2;
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    lat = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
